// File: rtl/addsub_acc_pkg.sv
// -----------------------------------------------------------------------------
// addsub_acc_pkg
// Shared types and constants for the add/sub frame accumulator.
//   acc_state_e : frame FSM states (ACCUM collects beats, DONE presents total)
//   ACC_MAX/MIN : saturation limits for the default accumulator width
//   EXT_W       : width of a reconstructed {carry,sum} beat for the default
//                 datapath width
// -----------------------------------------------------------------------------
package addsub_acc_pkg;

  localparam int WIDTH_DEF = 16;
  localparam int ACC_W_DEF = 24;
  localparam int EXT_W     = WIDTH_DEF + 1;

  localparam logic [ACC_W_DEF-1:0] ACC_MAX = {1'b0, {(ACC_W_DEF-1){1'b1}}};
  localparam logic [ACC_W_DEF-1:0] ACC_MIN = {1'b1, {(ACC_W_DEF-1){1'b0}}};

  typedef enum logic {
    ACCUM = 1'b0,
    DONE  = 1'b1
  } acc_state_e;

endpackage

// File: rtl/addsub_acc_satadd.sv
// -----------------------------------------------------------------------------
// addsub_acc_satadd
// Combinational signed saturating adder of ACC_W bits.
// Ports:
//   a_i, b_i : two's complement operands
//   sum_o    : a_i + b_i, clipped to the most positive / most negative value
//   clip_o   : 1 when the true sum did not fit and sum_o was clipped
// -----------------------------------------------------------------------------
module addsub_acc_satadd
  import addsub_acc_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF
) (
  input  logic [ACC_W-1:0] a_i,
  input  logic [ACC_W-1:0] b_i,
  output logic [ACC_W-1:0] sum_o,
  output logic             clip_o
);

  localparam logic [ACC_W-1:0] LIM_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] LIM_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  logic [ACC_W-1:0] raw_sum;

  assign raw_sum = a_i + b_i;

  // Overflow only possible when both operands share a sign and the wrapped
  // result flips it; the operand sign then tells which limit to clip to.
  assign clip_o = (a_i[ACC_W-1] == b_i[ACC_W-1]) && (raw_sum[ACC_W-1] != a_i[ACC_W-1]);
  assign sum_o  = clip_o ? (a_i[ACC_W-1] ? LIM_MIN : LIM_MAX) : raw_sum;

endmodule

// File: rtl/addsub_frame_accumulator.sv
// -----------------------------------------------------------------------------
// addsub_frame_accumulator
// Consumes {carry,sum} results of the 16-bit adder/subtractor, rebuilds the
// exact signed beat value, accumulates up to BLOCK_LEN beats (or fewer when
// flushed) with sticky saturation, and hands the frame total downstream.
// Ports:
//   clk, rst_n                 : clock, asynchronous active-low reset
//   in_valid/in_ready          : beat handshake
//   in_sum, in_carry, in_sub   : beat payload (in_sub=1 -> signed difference)
//   flush                      : close the current non-empty frame early
//   out_valid/out_ready        : frame result handshake
//   out_acc, out_count, out_sat: frame total, beat count, saturation seen
//   out_min, out_max           : smallest / largest beat of the frame, only
//                                when ADDSUB_ACC_MINMAX_EN is defined
// -----------------------------------------------------------------------------
module addsub_frame_accumulator
  import addsub_acc_pkg::*;
#(
  parameter int WIDTH     = WIDTH_DEF,
  parameter int ACC_W     = ACC_W_DEF,
  parameter int BLOCK_LEN = 16,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_sum,
  input  logic             in_carry,
  input  logic             in_sub,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_acc,
  output logic [CNT_W-1:0] out_count,
`ifdef ADDSUB_ACC_MINMAX_EN
  output logic [ACC_W-1:0] out_min,
  output logic [ACC_W-1:0] out_max,
`endif
  output logic             out_sat
);

  localparam logic [CNT_W-1:0] BLOCK_LEN_C = CNT_W'(BLOCK_LEN);

  acc_state_e       state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sat_q, sat_d;
  logic [ACC_W-1:0] out_acc_q, out_acc_d;
  logic [CNT_W-1:0] out_cnt_q, out_cnt_d;
  logic             out_sat_q, out_sat_d;
`ifdef ADDSUB_ACC_MINMAX_EN
  logic [ACC_W-1:0] min_q, min_d, max_q, max_d;
  logic [ACC_W-1:0] out_min_q, out_min_d, out_max_q, out_max_d;
`endif

  logic [ACC_W-1:0] beat_v;
  logic [ACC_W-1:0] add_sum;
  logic             add_clip;
  logic             accept;
  logic [CNT_W-1:0] cnt_inc;

  // Subtraction results are signed (carry doubles as sign); addition results
  // are a plain 17-bit unsigned magnitude.
  assign beat_v = in_sub ? {{(ACC_W-WIDTH-1){in_carry}}, in_carry, in_sum}
                         : {{(ACC_W-WIDTH-1){1'b0}},     in_carry, in_sum};

  assign accept  = in_valid && (state_q == ACCUM);
  assign cnt_inc = cnt_q + 1'b1;

  addsub_acc_satadd #(.ACC_W(ACC_W)) u_satadd (
    .a_i   (acc_q),
    .b_i   (beat_v),
    .sum_o (add_sum),
    .clip_o(add_clip)
  );

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    sat_d     = sat_q;
    out_acc_d = out_acc_q;
    out_cnt_d = out_cnt_q;
    out_sat_d = out_sat_q;
`ifdef ADDSUB_ACC_MINMAX_EN
    min_d     = min_q;
    max_d     = max_q;
    out_min_d = out_min_q;
    out_max_d = out_max_q;
`endif
    case (state_q)
      ACCUM: begin
        if (accept) begin
          cnt_d = cnt_inc;
          // Once clipped the total is pinned at the limit for the frame.
          if (!sat_q) begin
            acc_d = add_sum;
            sat_d = add_clip;
          end
`ifdef ADDSUB_ACC_MINMAX_EN
          if (cnt_q == '0 || $signed(beat_v) < $signed(min_q)) min_d = beat_v;
          if (cnt_q == '0 || $signed(beat_v) > $signed(max_q)) max_d = beat_v;
`endif
        end
        // A flush with an accepted beat closes the frame including that beat;
        // a flush on an empty frame is dropped.
        if ((accept && cnt_inc == BLOCK_LEN_C) || (flush && (accept || cnt_q != '0))) begin
          state_d   = DONE;
          out_acc_d = acc_d;
          out_cnt_d = cnt_d;
          out_sat_d = sat_d;
`ifdef ADDSUB_ACC_MINMAX_EN
          out_min_d = min_d;
          out_max_d = max_d;
`endif
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = ACCUM;
          acc_d   = '0;
          cnt_d   = '0;
          sat_d   = 1'b0;
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ACCUM;
      acc_q     <= '0;
      cnt_q     <= '0;
      sat_q     <= 1'b0;
      out_acc_q <= '0;
      out_cnt_q <= '0;
      out_sat_q <= 1'b0;
`ifdef ADDSUB_ACC_MINMAX_EN
      min_q     <= '0;
      max_q     <= '0;
      out_min_q <= '0;
      out_max_q <= '0;
`endif
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      sat_q     <= sat_d;
      out_acc_q <= out_acc_d;
      out_cnt_q <= out_cnt_d;
      out_sat_q <= out_sat_d;
`ifdef ADDSUB_ACC_MINMAX_EN
      min_q     <= min_d;
      max_q     <= max_d;
      out_min_q <= out_min_d;
      out_max_q <= out_max_d;
`endif
    end
  end

  // Handshake flags decode the state register only, so in_ready never
  // combinationally follows in_valid and DONE->ACCUM costs one idle cycle.
  assign in_ready  = (state_q == ACCUM);
  assign out_valid = (state_q == DONE);
  assign out_acc   = out_acc_q;
  assign out_count = out_cnt_q;
  assign out_sat   = out_sat_q;
`ifdef ADDSUB_ACC_MINMAX_EN
  assign out_min   = out_min_q;
  assign out_max   = out_max_q;
`endif

endmodule

// File: tb/tb_addsub_frame_accumulator.sv
// -----------------------------------------------------------------------------
// tb_addsub_frame_accumulator
// Two accumulators (ACC_W=24 and ACC_W=18, BLOCK_LEN=4) share one input
// stream; a frame-level reference model predicts handshake and results.
// -----------------------------------------------------------------------------
module tb_addsub_frame_accumulator;

  localparam int BL = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_carry = 1'b0;
  logic        in_sub = 1'b0;
  logic        flush = 1'b0;
  logic        out_ready = 1'b0;
  logic [15:0] in_sum = '0;

  logic        rdy_a, val_a, sat_a, rdy_b, val_b, sat_b;
  logic [23:0] acc_a;
  logic [17:0] acc_b;
  logic [7:0]  cnt_a, cnt_b;
`ifdef ADDSUB_ACC_MINMAX_EN
  logic [23:0] min_a, max_a;
  logic [17:0] min_b, max_b;
`endif

  always #5 clk = ~clk;

  addsub_frame_accumulator #(.WIDTH(16), .ACC_W(24), .BLOCK_LEN(BL), .CNT_W(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_a),
    .in_sum(in_sum), .in_carry(in_carry), .in_sub(in_sub), .flush(flush),
    .out_valid(val_a), .out_ready(out_ready), .out_acc(acc_a), .out_count(cnt_a),
`ifdef ADDSUB_ACC_MINMAX_EN
    .out_min(min_a), .out_max(max_a),
`endif
    .out_sat(sat_a)
  );

  addsub_frame_accumulator #(.WIDTH(16), .ACC_W(18), .BLOCK_LEN(BL), .CNT_W(8)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_b),
    .in_sum(in_sum), .in_carry(in_carry), .in_sub(in_sub), .flush(flush),
    .out_valid(val_b), .out_ready(out_ready), .out_acc(acc_b), .out_count(cnt_b),
`ifdef ADDSUB_ACC_MINMAX_EN
    .out_min(min_b), .out_max(max_b),
`endif
    .out_sat(sat_b)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  // ---------------- reference model ----------------
  bit     m_done;
  longint m_beats[$];
  longint e_acc_a, e_acc_b, e_min_a, e_max_a, e_min_b, e_max_b;
  bit     e_sat_a, e_sat_b;
  int     e_cnt;

  function automatic longint beat_val(bit c, logic [15:0] s, bit sb);
    longint v;
    v = (longint'(c) << 16) + longint'(s);
    if (sb && c) v = v - 131072;
    return v;
  endfunction

  function automatic longint to_bits(longint x, int w);
    return x & ((longint'(1) << w) - 1);
  endfunction

  task automatic frame_total(input int w, output longint acc_bits, output bit sat);
    longint lim_hi, lim_lo, acc, t;
    lim_hi = (longint'(1) << (w - 1)) - 1;
    lim_lo = -(longint'(1) << (w - 1));
    acc = 0;
    sat = 0;
    foreach (m_beats[i]) begin
      if (!sat) begin
        t = acc + m_beats[i];
        if (t > lim_hi)      begin acc = lim_hi; sat = 1; end
        else if (t < lim_lo) begin acc = lim_lo; sat = 1; end
        else acc = t;
      end
    end
    acc_bits = to_bits(acc, w);
  endtask

  task automatic close_frame();
    longint mn, mx;
    frame_total(24, e_acc_a, e_sat_a);
    frame_total(18, e_acc_b, e_sat_b);
    e_cnt = m_beats.size();
    mn = m_beats[0];
    mx = m_beats[0];
    foreach (m_beats[i]) begin
      if (m_beats[i] < mn) mn = m_beats[i];
      if (m_beats[i] > mx) mx = m_beats[i];
    end
    e_min_a = to_bits(mn, 24); e_max_a = to_bits(mx, 24);
    e_min_b = to_bits(mn, 18); e_max_b = to_bits(mx, 18);
    m_done = 1;
  endtask

  task automatic model_reset();
    m_done = 0;
    m_beats.delete();
    e_acc_a = 0; e_acc_b = 0; e_sat_a = 0; e_sat_b = 0; e_cnt = 0;
    e_min_a = 0; e_max_a = 0; e_min_b = 0; e_max_b = 0;
  endtask

  task automatic model_edge();
    if (!m_done) begin
      if (in_valid) m_beats.push_back(beat_val(in_carry, in_sum, in_sub));
      if ((in_valid && m_beats.size() == BL) || (flush && m_beats.size() > 0)) close_frame();
    end else if (out_ready) begin
      m_done = 0;
      m_beats.delete();
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".in_ready_a"},  longint'(rdy_a), longint'(!m_done));
    check({tag, ".in_ready_b"},  longint'(rdy_b), longint'(!m_done));
    check({tag, ".out_valid_a"}, longint'(val_a), longint'(m_done));
    check({tag, ".out_valid_b"}, longint'(val_b), longint'(m_done));
    check({tag, ".acc_a"},       longint'(acc_a), e_acc_a);
    check({tag, ".acc_b"},       longint'(acc_b), e_acc_b);
    check({tag, ".cnt_a"},       longint'(cnt_a), longint'(e_cnt));
    check({tag, ".cnt_b"},       longint'(cnt_b), longint'(e_cnt));
    check({tag, ".sat_a"},       longint'(sat_a), longint'(e_sat_a));
    check({tag, ".sat_b"},       longint'(sat_b), longint'(e_sat_b));
`ifdef ADDSUB_ACC_MINMAX_EN
    check({tag, ".min_a"},       longint'(min_a), e_min_a);
    check({tag, ".max_a"},       longint'(max_a), e_max_a);
    check({tag, ".min_b"},       longint'(min_b), e_min_b);
    check({tag, ".max_b"},       longint'(max_b), e_max_b);
`endif
  endtask

  // One clock: drive at the falling edge, update the model at the rising
  // edge, compare at the next falling edge.
  task automatic cyc(input string tag, input bit v, input bit c, input logic [15:0] s,
                     input bit sb, input bit fl, input bit rdy);
    in_valid = v; in_carry = c; in_sum = s; in_sub = sb; flush = fl; out_ready = rdy;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all(tag);
  endtask

  task automatic reset_pulse(input string tag);
    in_valid = 0; flush = 0; out_ready = 0;
    #2 rst_n = 0;
    #1 model_reset();
    check_all({tag, ".async"});
    @(posedge clk);
    @(negedge clk);
    check_all({tag, ".held"});
    rst_n = 1;
  endtask

  initial begin
    model_reset();
    rst_n = 0;
    #2 check_all("reset");
    @(negedge clk);
    rst_n = 1;

    // Four add beats; result must appear right after the fourth accept.
    cyc("tp1.b0", 1, 0, 16'h0001, 0, 0, 0);
    cyc("tp1.b1", 1, 0, 16'h0002, 0, 0, 0);
    cyc("tp1.b2", 1, 1, 16'h0000, 0, 0, 0);
    cyc("tp1.b3", 1, 0, 16'hFFFF, 0, 0, 0);
    check("tp1.const_acc", longint'(acc_a), 64'h020002);
    check("tp1.const_valid", longint'(val_a), 1);
    cyc("tp1.take", 0, 0, 16'h0000, 0, 0, 1);
    cyc("tp1.idle", 0, 0, 16'h0000, 0, 0, 0);

    // Single subtract beat of -5 flushed together with the beat.
    cyc("tp2.b0", 1, 1, 16'hFFFB, 1, 1, 0);
    check("tp2.const_acc", longint'(acc_a), 64'hFFFFFB);
    check("tp2.const_cnt", longint'(cnt_a), 1);
    cyc("tp2.take", 0, 0, 16'h0000, 0, 0, 1);

    // Back-pressure in DONE with in_valid held high: nothing may be taken.
    cyc("tp3.b0", 1, 0, 16'h0003, 0, 0, 0);
    cyc("tp3.fl", 0, 0, 16'h0000, 0, 1, 0);
    for (int i = 0; i < 5; i++) cyc("tp3.hold", 1, 0, 16'h1234, 0, 1, 0);
    cyc("tp3.take", 1, 0, 16'h1234, 0, 0, 1);
    cyc("tp3.r0", 1, 0, 16'h0007, 0, 0, 0);
    cyc("tp3.r1", 0, 0, 16'h0000, 0, 1, 0);
    check("tp3.const_acc", longint'(acc_a), 64'h7);
    cyc("tp3.take2", 0, 0, 16'h0000, 0, 0, 1);

    // Saturation in the 18-bit instance.
    cyc("tp4.b0", 1, 1, 16'hFFFF, 0, 0, 0);
    cyc("tp4.b1", 1, 1, 16'hFFFF, 0, 0, 0);
    cyc("tp4.b2", 1, 1, 16'hFFFF, 0, 1, 0);
    check("tp4.const_acc18", longint'(acc_b), 64'h1FFFF);
    check("tp4.const_sat18", longint'(sat_b), 1);
    cyc("tp4.take", 0, 0, 16'h0000, 0, 0, 1);

    // Empty flush is ignored.
    cyc("tp5.flush0", 0, 0, 16'h0000, 0, 1, 0);
    cyc("tp5.idle", 0, 0, 16'h0000, 0, 0, 0);

    // Reset mid-frame; next frame counts only new beats.
    cyc("tp6.b0", 1, 0, 16'h0011, 0, 0, 0);
    cyc("tp6.b1", 1, 0, 16'h0022, 0, 0, 0);
    reset_pulse("tp6.rst");
    for (int i = 0; i < BL; i++) cyc("tp6.post", 1, 0, 16'(i + 1), 0, 0, 0);
    check("tp6.const_cnt", longint'(cnt_a), BL);
    cyc("tp6.take", 0, 0, 16'h0000, 0, 0, 1);

    // Beats -3, 7, 0 for min/max tracking.
    cyc("tp7.b0", 1, 1, 16'hFFFD, 1, 0, 0);
    cyc("tp7.b1", 1, 0, 16'h0007, 1, 0, 0);
    cyc("tp7.b2", 1, 0, 16'h0000, 0, 1, 0);
`ifdef ADDSUB_ACC_MINMAX_EN
    check("tp7.const_min", longint'(min_a), 64'hFFFFFD);
    check("tp7.const_max", longint'(max_a), 64'h7);
`endif
    check("tp7.const_acc", longint'(acc_a), 64'h4);
    cyc("tp7.take", 0, 0, 16'h0000, 0, 0, 1);

    // Randomized traffic, with an occasional asynchronous reset.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 199) == 0) reset_pulse("rnd.rst");
      else cyc("rnd", ($urandom_range(0, 9) < 7), 1'($urandom), 16'($urandom),
               1'($urandom), ($urandom_range(0, 9) == 0), ($urandom_range(0, 1) == 1));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
